// File: rtl/exu_operand_fwd.sv
// exu_operand_fwd: operand forwarding/interlock scoreboard feeding the EXU input register
module exu_operand_fwd #(
  parameter int XLEN = 32,
  parameter int NSRC = 2,
  parameter int NSTAGE = 3,
  parameter int LOAD_SLOT = 2,
  parameter int AW = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NSRC*AW-1:0]     in_rs_addr,
  input  logic [NSRC-1:0]        in_rs_use,
  input  logic [NSRC*XLEN-1:0]   in_rs_data,
  input  logic [AW-1:0]          in_rd,
  input  logic                   in_wen,
  input  logic                   in_is_load,
  input  logic                   adv,
  input  logic                   flush,
  input  logic [NSTAGE*XLEN-1:0] stage_data,
  output logic                   out_valid,
  output logic [NSRC*XLEN-1:0]   out_rs_data,
  output logic [AW-1:0]          out_rd,
  output logic                   out_wen,
  output logic                   out_is_load,
  output logic [31:0]            stall_cnt
);
  logic [NSTAGE-1:1] rv, rw, rl;
  logic [NSTAGE-1:1][AW-1:0] rrd;
  logic [NSTAGE-1:0] sv, sw, sl;
  logic [NSTAGE-1:0][AW-1:0] srd;
  logic [NSRC*XLEN-1:0] fwd;
  logic [NSRC-1:0] hz;
  logic hazard, issue;
  assign sv = {rv, out_valid};
  assign sw = {rw, out_wen};
  assign sl = {rl, out_is_load};
  assign srd = {rrd, out_rd};
  always_comb begin
    fwd = in_rs_data;
    hz = '0;
    for (int i = 0; i < NSRC; i++)
      for (int s = NSTAGE - 1; s >= 0; s--)
        if (in_rs_use[i] && sv[s] && sw[s] && srd[s] == in_rs_addr[i*AW +: AW] && in_rs_addr[i*AW +: AW] != '0) begin
          fwd[i*XLEN +: XLEN] = stage_data[s*XLEN +: XLEN];
          hz[i] = sl[s] && (s < LOAD_SLOT);
        end
  end
  assign hazard = |hz;
  assign in_ready = (!out_valid | adv) & !hazard & !flush;
  assign issue = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rs_data <= '0;
      out_rd <= '0;
      out_wen <= 1'b0;
      out_is_load <= 1'b0;
      stall_cnt <= '0;
      rv <= '0;
      rw <= '0;
      rl <= '0;
      rrd <= '0;
    end else begin
      if (issue) begin
        out_valid <= 1'b1;
        out_rs_data <= fwd;
        out_rd <= in_rd;
        out_wen <= in_wen;
        out_is_load <= in_is_load;
      end else if (adv | flush) begin
        out_valid <= 1'b0;
      end
      if (adv) begin
        for (int k = NSTAGE - 1; k >= 2; k--) begin
          rv[k] <= rv[k-1];
          rw[k] <= rw[k-1];
          rl[k] <= rl[k-1];
          rrd[k] <= rrd[k-1];
        end
        rv[1] <= out_valid & !flush;
        rw[1] <= out_wen;
        rl[1] <= out_is_load;
        rrd[1] <= out_rd;
      end
      if (in_valid & hazard & !flush & ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_exu_operand_fwd.sv
// tb_exu_operand_fwd: directed scoreboard bench for exu_operand_fwd
module tb_exu_operand_fwd;
  logic clk, rst, in_valid, in_ready, in_wen, in_is_load, adv, flush;
  logic [9:0] in_rs_addr;
  logic [1:0] in_rs_use;
  logic [63:0] in_rs_data;
  logic [4:0] in_rd, out_rd;
  logic [95:0] stage_data;
  logic out_valid, out_wen, out_is_load;
  logic [63:0] out_rs_data;
  logic [31:0] stall_cnt;
  logic [68:0] q[$];
  logic [68:0] e;
  logic iss;
  int total = 0, bad = 0;
  exu_operand_fwd dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rs_use(in_rs_use), .in_rs_data(in_rs_data),
    .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load), .adv(adv), .flush(flush),
    .stage_data(stage_data), .out_valid(out_valid), .out_rs_data(out_rs_data),
    .out_rd(out_rd), .out_wen(out_wen), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    iss = in_valid && in_ready && !rst;
    #1;
    if (iss) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL issue: output with empty scoreboard, got %h", out_rs_data);
      end else begin
        e = q.pop_front();
        if ({out_rd, out_rs_data} !== e || !out_valid) begin
          bad++;
          $display("FAIL issue: got rd=%0d ops=%h v=%b expected rd=%0d ops=%h", out_rd, out_rs_data, out_valid, e[68:64], e[63:0]);
        end
      end
    end
  end
  task automatic drv(input logic [4:0] a0, a1, input logic [1:0] u, input logic [31:0] d0, d1,
                     input logic [4:0] rd, input logic w, l);
    in_valid = 1'b1;
    in_rs_addr = {a1, a0};
    in_rs_use = u;
    in_rs_data = {d1, d0};
    in_rd = rd;
    in_wen = w;
    in_is_load = l;
  endtask
  task automatic ins(input string name, input logic [4:0] a0, a1, input logic [1:0] u, input logic [31:0] d0, d1,
                     input logic [4:0] rd, input logic w, l, input logic [31:0] e0, e1, input int ew);
    int waits;
    drv(a0, a1, u, d0, d1, rd, w, l);
    waits = 0;
    #1;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for in_ready", name);
    end else begin
      q.push_back({rd, e1, e0});
      chk({name, " stall cycles"}, 64'(waits), 64'(ew));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; adv = 1'b1; flush = 1'b0; stage_data = '0;
    in_rs_addr = '0; in_rs_use = '0; in_rs_data = '0; in_rd = '0; in_wen = 1'b0; in_is_load = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_rs_data", out_rs_data, 64'd0);
    chk("rst out_rd/wen/ld", {out_rd, out_wen, out_is_load}, 64'd0);
    chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    ins("add_rf", 5, 6, 2'b11, 32'h11, 32'h22, 8, 1, 0, 32'h11, 32'h22, 0);
    chk("add stall_cnt", 64'(stall_cnt), 64'd0);
    ins("alu_x3", 0, 0, 2'b00, 32'h1, 32'h2, 3, 1, 0, 32'h1, 32'h2, 0);
    stage_data = {32'h0, 32'h0, 32'hAA};
    ins("use_x3", 3, 0, 2'b01, 32'h0, 32'h55, 9, 0, 0, 32'hAA, 32'h55, 0);
    ins("load_x7", 0, 0, 2'b00, 32'h0, 32'h0, 7, 1, 1, 32'h0, 32'h0, 0);
    stage_data = {32'hDEAD_BEEF, 32'h1234, 32'h5678};
    ins("use_x7", 7, 0, 2'b01, 32'h70, 32'h0, 9, 0, 0, 32'hDEAD_BEEF, 32'h0, 2);
    chk("loaduse stall_cnt", 64'(stall_cnt), 64'd2);
    ins("x4_a", 0, 0, 2'b00, 32'h0, 32'h0, 4, 1, 0, 32'h0, 32'h0, 0);
    ins("x10_b", 0, 0, 2'b00, 32'h0, 32'h0, 10, 1, 0, 32'h0, 32'h0, 0);
    ins("x4_c", 0, 0, 2'b00, 32'h0, 32'h0, 4, 1, 0, 32'h0, 32'h0, 0);
    stage_data = {32'h2, 32'hBB, 32'h1};
    ins("youngest", 4, 10, 2'b11, 32'h0, 32'h0, 9, 0, 0, 32'h1, 32'hBB, 0);
    ins("x4_a2", 0, 0, 2'b00, 32'h0, 32'h0, 4, 1, 0, 32'h0, 32'h0, 0);
    ins("x11_b2", 0, 0, 2'b00, 32'h0, 32'h0, 11, 1, 0, 32'h0, 32'h0, 0);
    ins("x4_ld", 0, 0, 2'b00, 32'h0, 32'h0, 4, 1, 1, 32'h0, 32'h0, 0);
    adv = 1'b0;
    stage_data = {32'h00C0_FFEE, 32'hBB, 32'h1};
    drv(4, 0, 2'b01, 32'h40, 32'h0, 9, 0, 0);
    #1;
    chk("unready young in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("no-adv stall_cnt", 64'(stall_cnt), 64'd5);
    adv = 1'b1;
    ins("use_x4_ld", 4, 0, 2'b01, 32'h40, 32'h0, 9, 0, 0, 32'h00C0_FFEE, 32'h0, 2);
    chk("after stall_cnt", 64'(stall_cnt), 64'd7);
    ins("x0_prod", 0, 0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 0);
    stage_data = {3{32'hBAD0}};
    ins("x0_use", 0, 0, 2'b11, 32'h77, 32'h78, 9, 0, 0, 32'h77, 32'h78, 0);
    ins("ld_x12", 0, 0, 2'b00, 32'h0, 32'h0, 12, 1, 1, 32'h0, 32'h0, 0);
    ins("nouse_x12", 12, 5, 2'b10, 32'h99, 32'h55, 9, 0, 0, 32'h99, 32'h55, 0);
    ins("x13_prod", 0, 0, 2'b00, 32'h0, 32'h0, 13, 1, 0, 32'h0, 32'h0, 0);
    flush = 1'b1;
    #1;
    chk("flush in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush out_valid", 64'(out_valid), 64'd0);
    ins("use_flushed", 13, 0, 2'b01, 32'h3131, 32'h0, 9, 0, 0, 32'h3131, 32'h0, 0);
    ins("ld_x14", 0, 0, 2'b00, 32'h0, 32'h0, 14, 1, 1, 32'h0, 32'h0, 0);
    adv = 1'b0;
    drv(14, 0, 2'b01, 32'hE0, 32'h0, 9, 0, 0);
    #1;
    chk("pre-rst in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst stall_cnt", 64'(stall_cnt), 64'd0);
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    adv = 1'b1;
    ins("post_rst_use", 14, 0, 2'b01, 32'hE0, 32'h0, 9, 0, 0, 32'hE0, 32'h0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
